mem_override_arbiter: RTL and testbench
=======================================

// Module: mem_override_arbiter
// PURPOSE
//  Memory-side responder for the override memory interface driven by the UART host.
//  Sits inside mu0 between the core memory port and the word RAM.
//  Grants the RAM to the host while overrideMemControl is high, stalling the core, and serves host reads/writes.
//  The core owns the RAM otherwise.
// PARAMETERS
//  DATA_W       16  RAM word width
//  ADDR_W       12  RAM address width; RAM depth is 2**ADDR_W words
//  RAM_LATENCY  1   cycles from ramCe to valid ramRData (1..4)
// PORTS
//  clk                 in   1       system clock
//  reset               in   1       asynchronous, active-low reset
//  overrideMemControl  in   1       host requests RAM ownership (level)
//  overrideMemStrobe   in   1       one-cycle access request from host
//  overrideMemRnW      in   1       1=read, 0=write; valid with strobe
//  overrideMemAddr     in   16      host word address; valid with strobe
//  overrideMemDataIn   in   DATA_W  host write data; valid with strobe
//  overrideMemDataOut  out  DATA_W  read data returned to host
//  overrideMemAck      out  1       one-cycle pulse: host access complete
//  overrideMemGranted  out  1       host owns the RAM
//  cpuMemReq           in   1       one-cycle core access request
//  cpuMemRnW           in   1       core 1=read, 0=write
//  cpuMemAddr          in   16      core word address
//  cpuMemWData         in   DATA_W  core write data
//  cpuMemRData         out  DATA_W  core read data
//  cpuMemReady         out  1       one-cycle pulse: core access complete
//  cpuHold             out  1       core must not issue cpuMemReq
//  ramCe, ramWe        out  1       RAM chip enable / write enable
//  ramAddr             out  ADDR_W  RAM address
//  ramWData            out  DATA_W  RAM write data
//  ramRData            in   DATA_W  RAM read data
// BEHAVIOUR
//  Reset value of every output is 0. State after reset is CPU_OWN.
//  States and transitions:
//   CPU_OWN
//    - cpuMemReq drives the RAM combinationally: ramCe=1, ramWe=~cpuMemRnW, low ADDR_W address bits.
//    - cpuMemReady pulses RAM_LATENCY cycles after cpuMemReq; reads capture ramRData into cpuMemRData on that cycle.
//   CPU_OWN -> DRAIN
//    - Taken when overrideMemControl is sampled high; cpuHold rises the same cycle.
//   DRAIN
//    - Waits for any in-flight core access to return cpuMemReady, then enters HOST_IDLE.
//    - If nothing is in flight, it is a single cycle.
//    - A cpuMemReq on the sampling cycle is accepted and completed before the grant.
//   HOST_IDLE
//    - overrideMemGranted=1.
//    - strobe with RnW=0 -> HOST_WR.
//    - strobe with RnW=1 -> HOST_RD.
//    - ~overrideMemControl -> RELEASE.
//   HOST_WR
//    - ramCe=ramWe=1 for one cycle with the registered address and data.
//    - overrideMemAck pulses the next cycle; then HOST_IDLE.
//   HOST_RD
//    - ramCe for one cycle.
//    - After RAM_LATENCY cycles, overrideMemDataOut <= ramRData and overrideMemAck pulses; then HOST_IDLE.
//   RELEASE
//    - Clears overrideMemGranted and cpuHold; back to CPU_OWN next cycle.
//  Latency from strobe to ack:
//   - write: 2 cycles
//   - read: RAM_LATENCY+1 cycles
//  overrideMemDataOut holds its value until the next host read completes.
//  Strobe outside HOST_IDLE is ignored and never acked; the host waits for ack before re-strobing.
//  Address range:
//   - If overrideMemAddr[15:ADDR_W] != 0, writes are dropped (no ramWe) and reads return 0.
//   - Both cases still ack with normal latency.
//   - Core addresses are truncated silently.
//  overrideMemControl falling mid-access: the access completes and acks, then RELEASE.
//   - Strobe and control-fall in the same HOST_IDLE cycle: the strobe wins, then release.
//  cpuMemReq while cpuHold=1 is a core protocol violation: ignored, no ready.
//  Async reset mid-access: aborts immediately, all outputs 0; no ack or ready is issued for the aborted access.
// TESTING
//  1. Reset released, core write 0x1234 @0x010 then read @0x010 -> cpuMemReady after RAM_LATENCY, cpuMemRData=0x1234.
//  2. Control=1, write 0xBEEF @0x0005 -> Granted, ramWe 1 cycle, ack 2 cycles after strobe; read @0x0005 -> DataOut=0xBEEF.
//  3. Control rises the cycle a core read is issued -> read completes with ready, then Granted; cpuHold high throughout.
//  4. Host write 0xAAAA @0xF000 (ADDR_W=12) -> no ramWe, ack still issued; read @0xF000 -> DataOut=0x0000, ack.
//  5. Drop control during HOST_RD -> ack with data, then RELEASE; cpuHold low 1 cycle after; a core read succeeds.
//  6. Assert reset during HOST_RD -> all outputs 0 at once, no ack, state CPU_OWN; a new grant works after release.

Source files
------------

// File: rtl/mem_override_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_override_arbiter
//  Description : Memory-side responder for the host override interface.
//                Sits between the core memory port and the word RAM and
//                grants the RAM to the host while overrideMemControl is
//                high. The core is held off while the host owns the RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_override_arbiter #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 12,   // 1..16
    parameter int RAM_LATENCY = 1     // 1..4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              overrideMemControl,
    input  logic              overrideMemStrobe,
    input  logic              overrideMemRnW,
    input  logic [15:0]       overrideMemAddr,
    input  logic [DATA_W-1:0] overrideMemDataIn,
    output logic [DATA_W-1:0] overrideMemDataOut,
    output logic              overrideMemAck,
    output logic              overrideMemGranted,

    input  logic              cpuMemReq,
    input  logic              cpuMemRnW,
    input  logic [15:0]       cpuMemAddr,
    input  logic [DATA_W-1:0] cpuMemWData,
    output logic [DATA_W-1:0] cpuMemRData,
    output logic              cpuMemReady,
    output logic              cpuHold,

    output logic              ramCe,
    output logic              ramWe,
    output logic [ADDR_W-1:0] ramAddr,
    output logic [DATA_W-1:0] ramWData,
    input  logic [DATA_W-1:0] ramRData
);

    typedef enum logic [2:0] {
        CPU_OWN   = 3'd0,
        DRAIN     = 3'd1,
        HOST_IDLE = 3'd2,
        HOST_WR   = 3'd3,
        HOST_RD   = 3'd4,
        RELEASE   = 3'd5
    } state_t;

    // Every pipeline stage except the one whose ready is visible this cycle.
    localparam logic [RAM_LATENCY-1:0] c_PIPE_MASK = {RAM_LATENCY{1'b1}} >> 1;
    localparam logic [1:0]             c_LAT_LAST  = 2'(RAM_LATENCY - 1);

    state_t                  r_state;
    logic                    r_granted;
    logic                    r_hold;
    logic                    r_ack;
    logic                    r_ack_rd;
    logic [1:0]              r_cnt;
    logic [ADDR_W-1:0]       r_host_addr;
    logic [DATA_W-1:0]       r_host_wdata;
    logic                    r_host_oob;
    logic [DATA_W-1:0]       r_host_rdata;
    logic [RAM_LATENCY-1:0]  r_pipe_vld;
    logic [RAM_LATENCY-1:0]  r_pipe_rd;
    logic [DATA_W-1:0]       r_cpu_rdata;

    logic                    w_host_oob;
    logic                    w_cpu_accept;
    logic                    w_drain_busy;
    logic                    w_cpu_rd_ret;
    logic [DATA_W-1:0]       w_host_rd_val;

    // Host addresses beyond the RAM are flagged; core addresses simply wrap.
    generate
        if (ADDR_W < 16) begin : g_addr_narrow
            logic w_unused_cpu_addr_hi;
            assign w_host_oob           = |overrideMemAddr[15:ADDR_W];
            assign w_unused_cpu_addr_hi = ^cpuMemAddr[15:ADDR_W];
        end else begin : g_addr_full
            assign w_host_oob = 1'b0;
        end
    endgenerate

    // Core accesses are only honoured while the core owns the RAM.
    assign w_cpu_accept  = cpuMemReq && (r_state == CPU_OWN);
    assign w_drain_busy  = |(r_pipe_vld & c_PIPE_MASK);
    assign w_cpu_rd_ret  = r_pipe_vld[RAM_LATENCY-1] & r_pipe_rd[RAM_LATENCY-1];
    assign w_host_rd_val = r_host_oob ? '0 : ramRData;

    assign overrideMemAck     = r_ack;
    assign overrideMemGranted = r_granted;
    assign cpuHold            = r_hold;
    assign cpuMemReady        = r_pipe_vld[RAM_LATENCY-1];

    // Read data is passed through on the completion cycle, then held.
    assign overrideMemDataOut = r_ack_rd ? w_host_rd_val : r_host_rdata;
    assign cpuMemRData        = w_cpu_rd_ret ? ramRData : r_cpu_rdata;

    // RAM port steering: core drives it directly, host uses registered request.
    always_comb begin
        ramCe    = 1'b0;
        ramWe    = 1'b0;
        ramAddr  = '0;
        ramWData = '0;
        if (reset) begin
            case (r_state)
                CPU_OWN: begin
                    if (cpuMemReq) begin
                        ramCe    = 1'b1;
                        ramWe    = ~cpuMemRnW;
                        ramAddr  = cpuMemAddr[ADDR_W-1:0];
                        ramWData = cpuMemWData;
                    end
                end
                HOST_WR: begin
                    ramCe    = ~r_host_oob;
                    ramWe    = ~r_host_oob;
                    ramAddr  = r_host_addr;
                    ramWData = r_host_wdata;
                end
                HOST_RD: begin
                    if (r_cnt == 2'd0) begin
                        ramCe   = ~r_host_oob;
                        ramAddr = r_host_addr;
                    end
                end
                default: ;
            endcase
        end
    end

    // Ownership state machine with registered grant, hold and ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= CPU_OWN;
            r_granted    <= 1'b0;
            r_hold       <= 1'b0;
            r_ack        <= 1'b0;
            r_ack_rd     <= 1'b0;
            r_cnt        <= 2'd0;
            r_host_addr  <= '0;
            r_host_wdata <= '0;
            r_host_oob   <= 1'b0;
        end else begin
            r_ack    <= 1'b0;
            r_ack_rd <= 1'b0;
            case (r_state)
                CPU_OWN: begin
                    if (overrideMemControl) begin
                        r_state <= DRAIN;
                        r_hold  <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (!w_drain_busy) begin
                        r_state   <= HOST_IDLE;
                        r_granted <= 1'b1;
                    end
                end
                HOST_IDLE: begin
                    // A strobe takes priority over a simultaneous release.
                    if (overrideMemStrobe) begin
                        r_host_addr  <= overrideMemAddr[ADDR_W-1:0];
                        r_host_wdata <= overrideMemDataIn;
                        r_host_oob   <= w_host_oob;
                        r_cnt        <= 2'd0;
                        r_state      <= overrideMemRnW ? HOST_RD : HOST_WR;
                    end else if (!overrideMemControl) begin
                        r_state <= RELEASE;
                    end
                end
                HOST_WR: begin
                    r_ack   <= 1'b1;
                    r_state <= HOST_IDLE;
                end
                HOST_RD: begin
                    if (r_cnt == c_LAT_LAST) begin
                        r_ack    <= 1'b1;
                        r_ack_rd <= 1'b1;
                        r_state  <= HOST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                RELEASE: begin
                    r_granted <= 1'b0;
                    r_hold    <= 1'b0;
                    r_state   <= CPU_OWN;
                end
                default: r_state <= CPU_OWN;
            endcase
        end
    end

    // Track core accesses in flight so ready lands RAM_LATENCY cycles later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pipe_vld <= '0;
            r_pipe_rd  <= '0;
        end else begin
            r_pipe_vld[0] <= w_cpu_accept;
            r_pipe_rd[0]  <= w_cpu_accept & cpuMemRnW;
            for (int k = 1; k < RAM_LATENCY; k++) begin
                r_pipe_vld[k] <= r_pipe_vld[k-1];
                r_pipe_rd[k]  <= r_pipe_rd[k-1];
            end
        end
    end

    // Hold the most recent read results for core and host.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cpu_rdata  <= '0;
            r_host_rdata <= '0;
        end else begin
            if (w_cpu_rd_ret) begin
                r_cpu_rdata <= ramRData;
            end
            if (r_ack_rd) begin
                r_host_rdata <= w_host_rd_val;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_override_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_override_arbiter
//  Description : Self-checking bench for mem_override_arbiter with a
//                behavioural RAM and a word-level memory reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_override_arbiter;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 12;
    localparam int LAT    = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ctrl = 1'b0, strobe = 1'b0, rnw_h = 1'b0;
    logic [15:0] addr_h = '0, din_h = '0;
    logic [15:0] dout_h;
    logic        ack_h, granted;
    logic        cpu_req = 1'b0, cpu_rnw = 1'b0;
    logic [15:0] cpu_addr = '0, cpu_wdata = '0;
    logic [15:0] cpu_rdata;
    logic        cpu_ready, cpu_hold;
    logic        ram_ce, ram_we;
    logic [11:0] ram_addr;
    logic [15:0] ram_wdata, ram_rdata;
    logic [65:0] all_outs;

    int n_vec = 0;
    int n_err = 0;
    int we_count = 0;

    mem_override_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RAM_LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .overrideMemControl(ctrl), .overrideMemStrobe(strobe), .overrideMemRnW(rnw_h),
        .overrideMemAddr(addr_h), .overrideMemDataIn(din_h), .overrideMemDataOut(dout_h),
        .overrideMemAck(ack_h), .overrideMemGranted(granted),
        .cpuMemReq(cpu_req), .cpuMemRnW(cpu_rnw), .cpuMemAddr(cpu_addr), .cpuMemWData(cpu_wdata),
        .cpuMemRData(cpu_rdata), .cpuMemReady(cpu_ready), .cpuHold(cpu_hold),
        .ramCe(ram_ce), .ramWe(ram_we), .ramAddr(ram_addr), .ramWData(ram_wdata), .ramRData(ram_rdata)
    );

    assign all_outs = {dout_h, ack_h, granted, cpu_rdata, cpu_ready, cpu_hold,
                       ram_ce, ram_we, ram_addr, ram_wdata};

    always #5 clk = ~clk;

    // Behavioural synchronous RAM: read data appears LAT cycles after ramCe.
    logic [15:0] ram [DEPTH] = '{default: 16'h0000};
    logic [15:0] rq  [LAT]   = '{default: 16'hDEAD};
    assign ram_rdata = rq[LAT-1];

    always @(posedge clk) begin
        if (ram_ce && ram_we) begin
            ram[ram_addr] <= ram_wdata;
            we_count      <= we_count + 1;
        end
        rq[0] <= (ram_ce && !ram_we) ? ram[ram_addr] : 16'hDEAD;
        for (int k = 1; k < LAT; k++) rq[k] <= rq[k-1];
    end

    // Reference memory: what every word should contain, by word address.
    logic [15:0] ref_mem [int];

    function automatic logic [15:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : 16'h0000;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    // ---------------- stimulus helpers (no checking inside) ----------------
    task automatic cpu_op(input logic rnw, input logic [15:0] a, input logic [15:0] d,
                          output logic [15:0] rd, output int lat);
        cpu_req = 1'b1; cpu_rnw = rnw; cpu_addr = a; cpu_wdata = d;
        lat = -1; rd = '0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 1) begin
                cpu_req = 1'b0; cpu_addr = 16'($urandom);
                cpu_wdata = 16'($urandom); cpu_rnw = 1'($urandom);
            end
            if (cpu_ready) begin lat = k; rd = cpu_rdata; break; end
        end
    endtask

    task automatic host_op(input logic rnw, input logic [15:0] a, input logic [15:0] d,
                           output logic [15:0] rd, output int lat);
        strobe = 1'b1; rnw_h = rnw; addr_h = a; din_h = d;
        lat = -1; rd = '0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 1) begin
                strobe = 1'b0; addr_h = 16'($urandom);
                din_h = 16'($urandom); rnw_h = 1'($urandom);
            end
            if (ack_h) begin lat = k; rd = dout_h; break; end
        end
    endtask

    task automatic do_grant(output int cyc);
        ctrl = 1'b1; cyc = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (granted) begin cyc = k; break; end
        end
    endtask

    task automatic do_release(output int cyc);
        ctrl = 1'b0; cyc = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (!granted && !cpu_hold) begin cyc = k; break; end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        cpu_req = 1'b1; cpu_addr = 16'h0123; cpu_wdata = 16'hFFFF; ctrl = 1'b1; strobe = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if (all_outs !== '0) begin
            n_err++; $display("FAIL reset_hold: outputs %h expected 0", all_outs);
        end
        cpu_req = 1'b0; ctrl = 1'b0; strobe = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        reset = 1'b1;
        @(negedge clk);
        n_vec++;
        if (all_outs !== '0) begin
            n_err++; $display("FAIL reset_release: outputs %h expected 0", all_outs);
        end
    endtask

    task automatic test_core_rw();
        logic [15:0] rd; int lat;
        cpu_op(1'b0, 16'h0010, 16'h1234, rd, lat);
        ref_mem[16'h010] = 16'h1234;
        n_vec++;
        if (lat !== LAT) begin n_err++; $display("FAIL core_wr_lat: got %0d expected %0d", lat, LAT); end
        cpu_op(1'b1, 16'h0010, 16'h0000, rd, lat);
        n_vec++;
        if (lat !== LAT) begin n_err++; $display("FAIL core_rd_lat: got %0d expected %0d", lat, LAT); end
        n_vec++;
        if (rd !== 16'h1234) begin n_err++; $display("FAIL core_rd_data: got %h expected 1234", rd); end
    endtask

    task automatic test_host_rw();
        logic [15:0] rd; int lat, cyc, we0;
        do_grant(cyc);
        n_vec++;
        if (cyc !== 2) begin n_err++; $display("FAIL grant_lat: got %0d expected 2", cyc); end
        n_vec++;
        if (cpu_hold !== 1'b1) begin n_err++; $display("FAIL grant_hold: got %b expected 1", cpu_hold); end
        we0 = we_count;
        host_op(1'b0, 16'h0005, 16'hBEEF, rd, lat);
        ref_mem[5] = 16'hBEEF;
        n_vec++;
        if (lat !== 2) begin n_err++; $display("FAIL host_wr_lat: got %0d expected 2", lat); end
        n_vec++;
        if (we_count - we0 !== 1) begin n_err++; $display("FAIL host_wr_we: got %0d pulses expected 1", we_count - we0); end
        host_op(1'b1, 16'h0005, 16'h0000, rd, lat);
        n_vec++;
        if (lat !== LAT + 1) begin n_err++; $display("FAIL host_rd_lat: got %0d expected %0d", lat, LAT + 1); end
        n_vec++;
        if (rd !== 16'hBEEF) begin n_err++; $display("FAIL host_rd_data: got %h expected beef", rd); end
        repeat (3) @(negedge clk);
        n_vec++;
        if (dout_h !== 16'hBEEF) begin n_err++; $display("FAIL host_rd_hold: got %h expected beef", dout_h); end
        do_release(cyc);
        n_vec++;
        if (cyc !== 2) begin n_err++; $display("FAIL release_lat: got %0d expected 2", cyc); end
    endtask

    task automatic test_drain();
        int ready_k = -1, grant_k = -1, cyc;
        logic hold_bad = 1'b0;
        logic [15:0] rd = '0;
        cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = 16'h0010; ctrl = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) cpu_req = 1'b0;
            if (!cpu_hold) hold_bad = 1'b1;
            if (cpu_ready && ready_k < 0) begin ready_k = k; rd = cpu_rdata; end
            if (granted) begin grant_k = k; break; end
        end
        n_vec++;
        if (ready_k !== LAT) begin n_err++; $display("FAIL drain_ready_lat: got %0d expected %0d", ready_k, LAT); end
        n_vec++;
        if (rd !== ref_rd(16'h010)) begin n_err++; $display("FAIL drain_rd_data: got %h expected %h", rd, ref_rd(16'h010)); end
        n_vec++;
        if (grant_k !== LAT + 1) begin n_err++; $display("FAIL drain_grant_lat: got %0d expected %0d", grant_k, LAT + 1); end
        n_vec++;
        if (hold_bad !== 1'b0) begin n_err++; $display("FAIL drain_hold: hold dropped, got %b expected 0", hold_bad); end
        do_release(cyc);
    endtask

    task automatic test_oob();
        logic [15:0] rd; int lat, cyc, we0;
        do_grant(cyc);
        we0 = we_count;
        host_op(1'b0, 16'hF000, 16'hAAAA, rd, lat);
        n_vec++;
        if (lat !== 2) begin n_err++; $display("FAIL oob_wr_lat: got %0d expected 2", lat); end
        n_vec++;
        if (we_count - we0 !== 0) begin n_err++; $display("FAIL oob_wr_we: got %0d pulses expected 0", we_count - we0); end
        host_op(1'b1, 16'hF000, 16'h0000, rd, lat);
        n_vec++;
        if (lat !== LAT + 1) begin n_err++; $display("FAIL oob_rd_lat: got %0d expected %0d", lat, LAT + 1); end
        n_vec++;
        if (rd !== 16'h0000) begin n_err++; $display("FAIL oob_rd_data: got %h expected 0000", rd); end
        host_op(1'b1, 16'h0000, 16'h0000, rd, lat);
        n_vec++;
        if (rd !== ref_rd(0)) begin n_err++; $display("FAIL oob_alias: got %h expected %h", rd, ref_rd(0)); end
        do_release(cyc);
    endtask

    task automatic test_release_mid_read();
        logic [15:0] rd = '0, rd2; int lat = -1, cyc, l2;
        logic hold_a1 = 1'b0, hold_a2 = 1'b1, gnt_a2 = 1'b1;
        do_grant(cyc);
        host_op(1'b0, 16'h0123, 16'h5A5A, rd2, l2);
        ref_mem[16'h123] = 16'h5A5A;
        strobe = 1'b1; rnw_h = 1'b1; addr_h = 16'h0123;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin strobe = 1'b0; ctrl = 1'b0; end
            if (lat < 0 && ack_h) begin lat = k; rd = dout_h; end
            if (lat > 0 && k == lat + 1) hold_a1 = cpu_hold;
            if (lat > 0 && k == lat + 2) begin hold_a2 = cpu_hold; gnt_a2 = granted; break; end
        end
        n_vec++;
        if (lat !== LAT + 1) begin n_err++; $display("FAIL rel_rd_lat: got %0d expected %0d", lat, LAT + 1); end
        n_vec++;
        if (rd !== 16'h5A5A) begin n_err++; $display("FAIL rel_rd_data: got %h expected 5a5a", rd); end
        n_vec++;
        if (hold_a1 !== 1'b1 || hold_a2 !== 1'b0 || gnt_a2 !== 1'b0) begin
            n_err++; $display("FAIL rel_hold: got %b%b gnt %b expected 10 gnt 0", hold_a1, hold_a2, gnt_a2);
        end
        cpu_op(1'b1, 16'hE123, 16'h0000, rd2, l2);
        n_vec++;
        if (rd2 !== 16'h5A5A || l2 !== LAT) begin
            n_err++; $display("FAIL rel_core_rd: got %h lat %0d expected 5a5a lat %0d", rd2, l2, LAT);
        end
    endtask

    task automatic test_strobe_and_release();
        logic [15:0] rd; int lat = -1, cyc, l2;
        logic hold_a2 = 1'b1;
        do_grant(cyc);
        strobe = 1'b1; rnw_h = 1'b0; addr_h = 16'h00AB; din_h = 16'h1357; ctrl = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) strobe = 1'b0;
            if (lat < 0 && ack_h) lat = k;
            if (lat > 0 && k == lat + 2) begin hold_a2 = cpu_hold; break; end
        end
        ref_mem[16'h0AB] = 16'h1357;
        n_vec++;
        if (lat !== 2) begin n_err++; $display("FAIL sr_ack_lat: got %0d expected 2", lat); end
        n_vec++;
        if (hold_a2 !== 1'b0) begin n_err++; $display("FAIL sr_hold: got %b expected 0", hold_a2); end
        cpu_op(1'b1, 16'h00AB, 16'h0000, rd, l2);
        n_vec++;
        if (rd !== 16'h1357) begin n_err++; $display("FAIL sr_core_rd: got %h expected 1357", rd); end
    endtask

    task automatic test_ignored();
        logic [15:0] rd; int cyc, l2;
        logic seen = 1'b0, ce_seen = 1'b0;
        strobe = 1'b1; rnw_h = 1'b0; addr_h = 16'h00AB; din_h = 16'h0BAD;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) strobe = 1'b0;
            if (ack_h || ram_ce) seen = 1'b1;
        end
        n_vec++;
        if (seen !== 1'b0) begin n_err++; $display("FAIL ign_strobe: got activity %b expected 0", seen); end
        do_grant(cyc);
        seen = 1'b0;
        cpu_req = 1'b1; cpu_rnw = 1'b0; cpu_addr = 16'h00AB; cpu_wdata = 16'hFFFF;
        #1 ce_seen = ram_ce;
        for (int k = 1; k <= LAT + 3; k++) begin
            @(negedge clk);
            if (k == 1) cpu_req = 1'b0;
            if (cpu_ready || ram_ce) seen = 1'b1;
        end
        n_vec++;
        if (ce_seen !== 1'b0 || seen !== 1'b0) begin
            n_err++; $display("FAIL ign_core: got ce %b ready %b expected 0 0", ce_seen, seen);
        end
        do_release(cyc);
        cpu_op(1'b1, 16'h00AB, 16'h0000, rd, l2);
        n_vec++;
        if (rd !== ref_rd(16'h0AB)) begin n_err++; $display("FAIL ign_core_mem: got %h expected %h", rd, ref_rd(16'h0AB)); end
    endtask

    task automatic test_reset_mid_read();
        logic [15:0] rd; int cyc, lat;
        logic seen = 1'b0;
        do_grant(cyc);
        strobe = 1'b1; rnw_h = 1'b1; addr_h = 16'h0005;
        @(negedge clk);
        strobe = 1'b0;
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if (all_outs !== '0) begin n_err++; $display("FAIL rst_mid_outs: got %h expected 0", all_outs); end
        ctrl = 1'b0;
        repeat (2) begin @(negedge clk); if (ack_h) seen = 1'b1; end
        reset = 1'b1;
        repeat (4) begin @(negedge clk); if (ack_h || granted || cpu_hold) seen = 1'b1; end
        n_vec++;
        if (seen !== 1'b0) begin n_err++; $display("FAIL rst_mid_quiet: got activity %b expected 0", seen); end
        cpu_op(1'b1, 16'h0005, 16'h0000, rd, lat);
        n_vec++;
        if (rd !== ref_rd(5) || lat !== LAT) begin
            n_err++; $display("FAIL rst_core_rd: got %h lat %0d expected %h lat %0d", rd, lat, ref_rd(5), LAT);
        end
        do_grant(cyc);
        n_vec++;
        if (cyc !== 2) begin n_err++; $display("FAIL rst_regrant: got %0d expected 2", cyc); end
        host_op(1'b1, 16'h0005, 16'h0000, rd, lat);
        n_vec++;
        if (rd !== ref_rd(5)) begin n_err++; $display("FAIL rst_host_rd: got %h expected %h", rd, ref_rd(5)); end
        do_release(cyc);
    endtask

    task automatic test_random();
        logic [15:0] rd, a, d; int lat, cyc, nops, lo; logic rnw;
        for (int it = 0; it < 40; it++) begin
            lo = int'($urandom_range(0, 15)) * 7;
            if ($urandom_range(0, 2) != 2) begin
                rnw = 1'($urandom); d = 16'($urandom);
                a = {4'($urandom), 12'(lo)};
                cpu_op(rnw, a, d, rd, lat);
                n_vec++;
                if (lat !== LAT) begin n_err++; $display("FAIL rnd_core_lat: got %0d expected %0d", lat, LAT); end
                if (!rnw) ref_mem[lo] = d;
                else begin
                    n_vec++;
                    if (rd !== ref_rd(lo)) begin n_err++; $display("FAIL rnd_core_rd @%h: got %h expected %h", a, rd, ref_rd(lo)); end
                end
            end else begin
                do_grant(cyc);
                n_vec++;
                if (cyc !== 2) begin n_err++; $display("FAIL rnd_grant: got %0d expected 2", cyc); end
                nops = int'($urandom_range(1, 4));
                for (int j = 0; j < nops; j++) begin
                    lo = int'($urandom_range(0, 15)) * 7;
                    a = ($urandom_range(0, 3) == 0) ? {4'($urandom_range(1, 15)), 12'($urandom)} : 16'(lo);
                    rnw = 1'($urandom); d = 16'($urandom);
                    host_op(rnw, a, d, rd, lat);
                    n_vec++;
                    if (lat !== (rnw ? LAT + 1 : 2)) begin
                        n_err++; $display("FAIL rnd_host_lat: got %0d expected %0d", lat, rnw ? LAT + 1 : 2);
                    end
                    if (!rnw && a < 16'(DEPTH)) ref_mem[int'(a)] = d;
                    if (rnw) begin
                        n_vec++;
                        if (rd !== ((a < 16'(DEPTH)) ? ref_rd(int'(a)) : 16'h0000)) begin
                            n_err++; $display("FAIL rnd_host_rd @%h: got %h expected %h", a, rd,
                                              (a < 16'(DEPTH)) ? ref_rd(int'(a)) : 16'h0000);
                        end
                    end
                end
                do_release(cyc);
                n_vec++;
                if (cyc !== 2) begin n_err++; $display("FAIL rnd_release: got %0d expected 2", cyc); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_core_rw();
        test_host_rw();
        test_drain();
        test_oob();
        test_release_mid_read();
        test_strobe_and_release();
        test_ignored();
        test_reset_mid_read();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
